imem_loader: RTL and testbench

Write-side companion to the instruction memory. It receives a program image as a byte stream over a valid/ready handshake and checks the header length and the trailing XOR checksum. It packs little-endian bytes into 32-bit words and drives a one-word-per-pulse write port into the instruction memory array. It holds the core in reset until a load completes cleanly, so a fresh program can replace the hard-coded one without re-synthesis.

---
 rtl/imem_loader_pkg.sv | 23 ++
 rtl/imem_loader_byte_packer.sv | 45 ++++
 rtl/imem_loader.sv | 136 +++++++++++++
 tb/tb_imem_loader.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// rtl/imem_loader_pkg.sv - shared types and constants for the instruction memory loader
package imem_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN0,
        ST_LEN1,
        ST_DATA,
        ST_WR,
        ST_CSUM,
        ST_DONE,
        ST_ERR
    } state_t;

    localparam int BYTES_PER_WORD = 4;
    localparam int LEN_BYTES      = 2;

    // States in which a stream byte may be accepted.
    function automatic logic state_accepts(state_t s);
        return (s == ST_LEN0) || (s == ST_LEN1) || (s == ST_DATA) || (s == ST_CSUM);
    endfunction

endpackage

// File: rtl/imem_loader_byte_packer.sv
// rtl/imem_loader_byte_packer.sv - little-endian byte-to-word packer
//
// Ports:
//   i_clk, i_arst_n : clock, asynchronous active-low reset
//   i_clr           : synchronous clear of word and byte count
//   i_accept        : a byte is transferred this cycle
//   i_byte          : the byte being transferred
//   o_word          : packed word; complete the cycle after o_last
//   o_last          : this accept completes a word
module imem_loader_byte_packer
    import imem_loader_pkg::*;
#(
    parameter int N = 32
) (
    input  logic         i_clk,
    input  logic         i_arst_n,
    input  logic         i_clr,
    input  logic         i_accept,
    input  logic [7:0]   i_byte,
    output logic [N-1:0] o_word,
    output logic         o_last
);

    localparam int CNTW = $clog2(BYTES_PER_WORD);

    logic [CNTW-1:0] cnt;

    assign o_last = i_accept && (cnt == CNTW'(BYTES_PER_WORD - 1));

    // Shifting in from the top leaves the first byte in bits [7:0] once the
    // word is full.
    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            cnt    <= '0;
            o_word <= '0;
        end else if (i_clr) begin
            cnt    <= '0;
            o_word <= '0;
        end else if (i_accept) begin
            cnt    <= cnt + CNTW'(1);
            o_word <= {i_byte, o_word[N-1:8]};
        end
    end

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - streams a program image into instruction memory and gates core reset
//
// Ports:
//   i_clk, i_arst_n        : clock, asynchronous active-low reset
//   i_start                : pulse to begin a load (ignored while busy)
//   i_byte_valid, i_byte   : byte stream in; o_byte_ready completes the handshake
//   o_we, o_waddr, o_wdata : one-cycle word write into instruction memory
//   o_busy, o_done, o_err  : load status
//   o_core_rst_n           : core reset, released only after a clean load
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int N     = 32,
    parameter int DEPTH = 77
) (
    input  logic         i_clk,
    input  logic         i_arst_n,
    input  logic         i_start,
    input  logic         i_byte_valid,
    input  logic [7:0]   i_byte,
    output logic         o_byte_ready,
    output logic         o_we,
    output logic [N-1:0] o_waddr,
    output logic [N-1:0] o_wdata,
    output logic         o_busy,
    output logic         o_done,
    output logic         o_err,
    output logic         o_core_rst_n
);

    localparam int IDXW = $clog2(DEPTH + 1);

    state_t          state, state_nxt;
    logic [15:0]     count;
    logic [IDXW-1:0] word_idx;
    logic [7:0]      csum;

    logic            accept;
    logic            load_start;
    logic            data_accept;
    logic            word_full;
    logic            last_word;
    logic [15:0]     len_full;

    assign accept      = i_byte_valid && o_byte_ready;
    assign data_accept = accept && (state == ST_DATA);
    assign load_start  = i_start && ((state == ST_IDLE) || (state == ST_DONE) || (state == ST_ERR));
    assign len_full    = {i_byte, count[7:0]};
    assign last_word   = ({{(16-IDXW){1'b0}}, word_idx} + 16'd1) == count;

    imem_loader_byte_packer #(.N(N)) u_packer (
        .i_clk    (i_clk),
        .i_arst_n (i_arst_n),
        .i_clr    (load_start),
        .i_accept (data_accept),
        .i_byte   (i_byte),
        .o_word   (o_wdata),
        .o_last   (word_full)
    );

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (i_start) state_nxt = ST_LEN0;
            end
            ST_LEN0: begin
                if (accept) state_nxt = ST_LEN1;
            end
            ST_LEN1: begin
                if (accept) begin
                    if (len_full > 16'(DEPTH))  state_nxt = ST_ERR;
                    else if (len_full == 16'd0) state_nxt = ST_CSUM;
                    else                        state_nxt = ST_DATA;
                end
            end
            ST_DATA: begin
                if (word_full) state_nxt = ST_WR;
            end
            ST_WR: begin
                state_nxt = last_word ? ST_CSUM : ST_DATA;
            end
            ST_CSUM: begin
                if (accept) state_nxt = (i_byte == csum) ? ST_DONE : ST_ERR;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Counters and checksum; all cleared together when a load is launched.
    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            count    <= '0;
            word_idx <= '0;
            csum     <= '0;
        end else if (load_start) begin
            count    <= '0;
            word_idx <= '0;
            csum     <= '0;
        end else begin
            if (accept && state == ST_LEN0) count[7:0]  <= i_byte;
            if (accept && state == ST_LEN1) count[15:8] <= i_byte;
            if (data_accept)                csum        <= csum ^ i_byte;
            if (state == ST_WR && !last_word) word_idx  <= word_idx + IDXW'(1);
        end
    end

    // Flopped from the next state so none of these depends combinationally
    // on the handshake inputs.
    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            o_we         <= 1'b0;
            o_byte_ready <= 1'b0;
            o_core_rst_n <= 1'b0;
        end else begin
            o_we         <= (state_nxt == ST_WR);
            o_byte_ready <= state_accepts(state_nxt);
            o_core_rst_n <= (state_nxt == ST_DONE);
        end
    end

    // word_idx only advances at the end of WR, so it is stable while o_we is high.
    assign o_waddr = {{(N-IDXW-2){1'b0}}, word_idx, 2'b00};
    assign o_busy  = (state != ST_IDLE) && (state != ST_DONE) && (state != ST_ERR);
    assign o_done  = (state == ST_DONE);
    assign o_err   = (state == ST_ERR);

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - self-checking bench for imem_loader
module tb_imem_loader;

    logic        i_clk = 1'b0;
    logic        i_arst_n = 1'b0;
    logic        i_start = 1'b0;
    logic        i_byte_valid = 1'b0;
    logic [7:0]  i_byte = 8'h00;
    logic        o_byte_ready;
    logic        o_we;
    logic [31:0] o_waddr;
    logic [31:0] o_wdata;
    logic        o_busy;
    logic        o_done;
    logic        o_err;
    logic        o_core_rst_n;

    int          errors = 0;
    int          checks = 0;
    int          we_count = 0;
    logic [31:0] last_waddr = 32'h0;
    logic [63:0] sb[$];
    logic [31:0] img[$];

    always #5 i_clk = ~i_clk;

    imem_loader #(.N(32), .DEPTH(77)) dut (
        .i_clk        (i_clk),
        .i_arst_n     (i_arst_n),
        .i_start      (i_start),
        .i_byte_valid (i_byte_valid),
        .i_byte       (i_byte),
        .o_byte_ready (o_byte_ready),
        .o_we         (o_we),
        .o_waddr      (o_waddr),
        .o_wdata      (o_wdata),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_err        (o_err),
        .o_core_rst_n (o_core_rst_n)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Write-port monitor: every strobe must match the next scoreboard entry.
    always @(negedge i_clk) begin
        logic [63:0] e;
        if (o_we) begin
            we_count++;
            last_waddr = o_waddr;
            if (sb.size() == 0) begin
                check("we_unexpected", o_waddr, 32'hFFFF_FFFF);
            end else begin
                e = sb.pop_front();
                check("waddr", o_waddr, e[63:32]);
                check("wdata", o_wdata, e[31:0]);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // All tasks start and end just after a falling edge.
    task automatic pulse_start();
        i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        i_byte_valid = 1'b0;
        repeat (gap) @(negedge i_clk);
        i_byte = b;
        i_byte_valid = 1'b1;
        n = 0;
        while (!o_byte_ready && n < 100) begin
            @(negedge i_clk);
            n++;
        end
        if (n >= 100) check("ready_timeout", 32'd0, 32'd1);
        @(negedge i_clk);
        i_byte_valid = 1'b0;
    endtask

    task automatic run_load(input int cnt, input bit bad, input int maxgap, input int stop_at);
        logic [7:0]  cs;
        logic [15:0] c16;
        logic [31:0] w;
        logic [7:0]  b;
        int          nb;
        cs  = 8'h00;
        nb  = 0;
        c16 = cnt[15:0];
        pulse_start();
        send_byte(c16[7:0], int'($urandom_range(maxgap, 0)));
        send_byte(c16[15:8], int'($urandom_range(maxgap, 0)));
        for (int wi = 0; wi < cnt; wi++) begin
            w = img[wi];
            for (int k = 0; k < 4; k++) begin
                if (stop_at >= 0 && nb == stop_at) return;
                b  = w[8*k +: 8];
                cs = cs ^ b;
                if (k == 3) sb.push_back({32'(wi) << 2, w});
                send_byte(b, int'($urandom_range(maxgap, 0)));
                nb++;
            end
        end
        send_byte(bad ? (cs ^ 8'h01) : cs, int'($urandom_range(maxgap, 0)));
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_we"},      32'(o_we),         32'd0);
        check({tag, "_waddr"},   o_waddr,           32'd0);
        check({tag, "_wdata"},   o_wdata,           32'd0);
        check({tag, "_ready"},   32'(o_byte_ready), 32'd0);
        check({tag, "_busy"},    32'(o_busy),       32'd0);
        check({tag, "_done"},    32'(o_done),       32'd0);
        check({tag, "_err"},     32'(o_err),        32'd0);
        check({tag, "_core_rn"}, 32'(o_core_rst_n), 32'd0);
    endtask

    initial begin
        int base;

        // Reset state
        repeat (3) @(negedge i_clk);
        check_idle_outputs("rst");
        i_arst_n = 1'b1;
        repeat (2) @(negedge i_clk);
        check_idle_outputs("post_rst");

        // Two-word clean load
        img.delete();
        img.push_back(32'h00A0_0093);
        img.push_back(32'h0050_0113);
        base = we_count;
        run_load(2, 1'b0, 0, -1);
        check("t1_done",    32'(o_done),       32'd1);
        check("t1_err",     32'(o_err),        32'd0);
        check("t1_core_rn", 32'(o_core_rst_n), 32'd1);
        check("t1_busy",    32'(o_busy),       32'd0);
        check("t1_ready",   32'(o_byte_ready), 32'd0);
        check("t1_writes",  32'(we_count - base), 32'd2);

        // Same image, bad checksum
        base = we_count;
        run_load(2, 1'b1, 2, -1);
        check("t2_done",    32'(o_done),       32'd0);
        check("t2_err",     32'(o_err),        32'd1);
        check("t2_core_rn", 32'(o_core_rst_n), 32'd0);
        check("t2_writes",  32'(we_count - base), 32'd2);

        // Oversize length aborts right after the second length byte
        base = we_count;
        pulse_start();
        send_byte(8'h4E, 0);
        send_byte(8'h00, 0);
        check("t3_err",     32'(o_err),        32'd1);
        check("t3_ready",   32'(o_byte_ready), 32'd0);
        check("t3_core_rn", 32'(o_core_rst_n), 32'd0);
        repeat (3) @(negedge i_clk);
        check("t3_writes",  32'(we_count - base), 32'd0);

        // Zero-length load, then restart from DONE
        base = we_count;
        run_load(0, 1'b0, 1, -1);
        check("t4_done",    32'(o_done),       32'd1);
        check("t4_core_rn", 32'(o_core_rst_n), 32'd1);
        check("t4_writes",  32'(we_count - base), 32'd0);
        pulse_start();
        check("t4_restart_core_rn", 32'(o_core_rst_n), 32'd0);
        check("t4_restart_busy",    32'(o_busy),       32'd1);
        check("t4_restart_ready",   32'(o_byte_ready), 32'd1);
        check("t4_restart_done",    32'(o_done),       32'd0);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        check("t4_redo_done", 32'(o_done), 32'd1);

        // Full-depth load with random source gaps
        img.delete();
        for (int i = 0; i < 77; i++) img.push_back($urandom);
        base = we_count;
        run_load(77, 1'b0, 7, -1);
        check("t5_done",       32'(o_done),       32'd1);
        check("t5_core_rn",    32'(o_core_rst_n), 32'd1);
        check("t5_writes",     32'(we_count - base), 32'd77);
        check("t5_last_waddr", last_waddr,        32'h130);
        check("t5_sb_empty",   32'(sb.size()),    32'd0);

        // Reset in the middle of the third word
        img.delete();
        for (int i = 0; i < 5; i++) img.push_back($urandom);
        run_load(5, 1'b0, 1, 10);
        check("t6_busy_before", 32'(o_busy), 32'd1);
        base = we_count;
        i_arst_n = 1'b0;
        #1;
        check_idle_outputs("t6_arst");
        repeat (4) @(negedge i_clk);
        i_arst_n = 1'b1;
        repeat (4) @(negedge i_clk);
        check("t6_no_we",     32'(we_count - base), 32'd0);
        check("t6_idle_busy", 32'(o_busy),          32'd0);
        base = we_count;
        run_load(5, 1'b0, 3, -1);
        check("t6_reload_done",   32'(o_done),          32'd1);
        check("t6_reload_core",   32'(o_core_rst_n),    32'd1);
        check("t6_reload_writes", 32'(we_count - base), 32'd5);
        check("t6_sb_empty",      32'(sb.size()),       32'd0);

        repeat (2) @(negedge i_clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
